// File: rtl/dbg_clock_gen.sv
// Debug clock generator: produces a glitch-free registered dbg_clk from the board clock,
// either one debounced single step at a time or free-running at a divided rate.

module dbg_clock_gen_debounce #(
    parameter int CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Any sample that agrees with the accepted level restarts the stability count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module dbg_clock_gen #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PULSE_CYCLES    = 4,
    parameter int RUN_HALF        = 6000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_step,
    input  logic        run,
    input  logic        halt,
    output logic        dbg_clk,
    output logic        step_busy,
    output logic [15:0] cycle_count
);
    localparam int PW  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int RW  = (RUN_HALF > 1) ? $clog2(RUN_HALF) : 1;
    localparam int PHW = (PW > RW) ? PW : RW;
    localparam logic [PHW-1:0] PULSE_LAST = PHW'(PULSE_CYCLES - 1);
    localparam logic [PHW-1:0] RUN_LAST   = PHW'(RUN_HALF - 1);

    typedef enum logic [1:0] {IDLE, STEP_HI, STEP_LO, RUN} state_t;

    state_t         state;
    logic [PHW-1:0] phase;
    logic           step_level;
    logic           step_level_q;
    logic           run_level;
    logic           step_req;

    dbg_clock_gen_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_step),
        .level (step_level)
    );

    dbg_clock_gen_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (run),
        .level (run_level)
    );

    assign step_req = step_level & ~step_level_q;

    // Every dbg_clk rising edge is issued from exactly one branch below, which also bumps cycle_count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= '0;
            dbg_clk      <= 1'b0;
            step_busy    <= 1'b0;
            cycle_count  <= '0;
            step_level_q <= 1'b0;
        end else begin
            step_level_q <= step_level;
            case (state)
                IDLE: begin
                    phase <= '0;
                    if (run_level && !halt) begin
                        state       <= RUN;
                        dbg_clk     <= 1'b1;
                        cycle_count <= cycle_count + 1'b1;
                    end else if (step_req) begin
                        state       <= STEP_HI;
                        dbg_clk     <= 1'b1;
                        step_busy   <= 1'b1;
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                STEP_HI: begin
                    if (phase == PULSE_LAST) begin
                        state   <= STEP_LO;
                        dbg_clk <= 1'b0;
                        phase   <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                STEP_LO: begin
                    if (phase == PULSE_LAST) begin
                        state     <= IDLE;
                        step_busy <= 1'b0;
                        phase     <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                RUN: begin
                    // Stop decisions are only taken at the end of a full low half.
                    if (phase == RUN_LAST) begin
                        phase <= '0;
                        if (dbg_clk) begin
                            dbg_clk <= 1'b0;
                        end else if (!run_level || halt) begin
                            state <= IDLE;
                        end else begin
                            dbg_clk     <= 1'b1;
                            cycle_count <= cycle_count + 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    dbg_clk <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dbg_clock_gen.sv
// Bench for dbg_clock_gen: a schedule-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized button/run/halt activity.

module tb_dbg_clock_gen;
    localparam int D  = 4;
    localparam int P  = 2;
    localparam int RH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_step = 1'b0;
    logic        run = 1'b0;
    logic        halt = 1'b0;
    logic        dbg_clk;
    logic        step_busy;
    logic [15:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    dbg_clock_gen #(
        .DEBOUNCE_CYCLES (D),
        .PULSE_CYCLES    (P),
        .RUN_HALF        (RH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_step    (btn_step),
        .run         (run),
        .halt        (halt),
        .dbg_clk     (dbg_clk),
        .step_busy   (step_busy),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_dbg(input logic val, input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (dbg_clk !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, dbg_clk, val);
    endtask

    // Reference model: raw-sample histories for the conditioned inputs, and an activity
    // timer t whose value alone decides dbg_clk within a step or a run.
    bit          step_hist[$];
    bit          run_hist[$];
    bit          m_deb_step, m_deb_step_prev, m_deb_run;
    int          m_mode;  // 0 idle, 1 stepping, 2 running
    int          m_t;
    bit          m_clk, m_busy, m_req, m_old_clk;
    logic [15:0] m_count;
    logic [15:0] count_offset = '0;
    logic [15:0] exp_cnt;

    function automatic bit flip_due(input bit hist[$], input bit level);
        for (int i = 1; i <= D; i++)
            if (hist[i] == level) return 1'b0;
        return 1'b1;
    endfunction

    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            step_hist = {};
            run_hist  = {};
            for (int i = 0; i < D + 2; i++) begin
                step_hist.push_front(1'b0);
                run_hist.push_front(1'b0);
            end
            m_deb_step = 0; m_deb_step_prev = 0; m_deb_run = 0;
            m_mode = 0; m_t = 0; m_clk = 0; m_busy = 0; m_count = '0;
        end else begin
            m_req     = m_deb_step && !m_deb_step_prev;
            m_old_clk = m_clk;
            case (m_mode)
                0: begin
                    if (m_deb_run && !halt) begin m_mode = 2; m_t = 0; end
                    else if (m_req) begin m_mode = 1; m_t = 0; end
                end
                1: begin
                    m_t++;
                    if (m_t == 2 * P) m_mode = 0;
                end
                default: begin
                    m_t++;
                    if (m_t == 2 * RH) begin
                        m_t = 0;
                        if (!m_deb_run || halt) m_mode = 0;
                    end
                end
            endcase
            m_clk  = (m_mode == 1 && m_t < P) || (m_mode == 2 && ((m_t / RH) % 2) == 0);
            m_busy = (m_mode == 1);
            if (m_clk && !m_old_clk) m_count = m_count + 16'd1;
            m_deb_step_prev = m_deb_step;
            if (flip_due(step_hist, m_deb_step)) m_deb_step = !m_deb_step;
            if (flip_due(run_hist, m_deb_run)) m_deb_run = !m_deb_run;
            step_hist.push_front(btn_step);
            run_hist.push_front(run);
            while (step_hist.size() > D + 2) void'(step_hist.pop_back());
            while (run_hist.size() > D + 2) void'(run_hist.pop_back());
        end
    end

    always begin
        @(negedge clk);
        if (cmp_en && !rst) begin
            exp_cnt = m_count + count_offset;
            check("dbg_clk", dbg_clk, m_clk);
            check("step_busy", step_busy, m_busy);
            check("cycle_count", cycle_count, exp_cnt);
        end
    end

    int rises, fall1, cyc, hl, first_hi, hi_cnt, busy_cnt;
    int rise_pos[10];
    bit prev, saw_hi, saw_busy;

    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_dbg_clk", dbg_clk, 0);
        check("reset_step_busy", step_busy, 0);
        check("reset_cycle_count", cycle_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);

        // Clean single step: the edge after this negedge is E.
        btn_step = 1'b1;
        first_hi = -1; hi_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dbg_clk) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = k;
            end
            if (step_busy) busy_cnt++;
        end
        check("step_first_high", first_hi, 6);
        check("step_high_len", hi_cnt, 2);
        check("step_busy_len", busy_cnt, 4);
        check("step_count", cycle_count, 1);
        btn_step = 1'b0;
        repeat (10) @(negedge clk);

        // Bounce: toggling every 2 cycles never settles long enough.
        saw_hi = 0;
        for (int i = 0; i < 10; i++) begin
            btn_step = ~btn_step;
            repeat (2) begin
                @(negedge clk);
                if (dbg_clk) saw_hi = 1;
            end
        end
        btn_step = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (dbg_clk) saw_hi = 1;
        end
        check("bounce_no_pulse", saw_hi, 0);
        check("bounce_count", cycle_count, 1);

        // Press during an active step does not produce a second step.
        btn_step = 1'b1;
        cyc = 0;
        while (!step_busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_seen", step_busy, 1);
        btn_step = 1'b0;
        @(negedge clk);
        btn_step = 1'b1;
        repeat (16) @(negedge clk);
        check("ignored_press_count", cycle_count, 2);
        btn_step = 1'b0;
        repeat (10) @(negedge clk);

        // Free run: ten rising edges, period 6, high 3.
        run = 1'b1;
        rises = 0; fall1 = -1; cyc = 0; prev = dbg_clk;
        while (rises < 10 && cyc < 150) begin
            @(negedge clk);
            cyc++;
            if (dbg_clk && !prev) begin
                rise_pos[rises] = cyc;
                rises++;
            end
            if (!dbg_clk && prev && fall1 < 0) fall1 = cyc;
            prev = dbg_clk;
        end
        check("run_rises", rises, 10);
        check("run_count", cycle_count, 12);
        check("run_period", rise_pos[2] - rise_pos[1], 6);
        check("run_high", fall1 - rise_pos[0], 3);

        // Halt one cycle into a high half: full high, full low, then idle.
        wait_dbg(1'b0, 10, "halt_wait_low");
        wait_dbg(1'b1, 10, "halt_wait_high");
        halt = 1'b1;
        hl = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dbg_clk) hl++;
            else break;
        end
        saw_hi = 0;
        repeat (12) begin
            @(negedge clk);
            if (dbg_clk) saw_hi = 1;
        end
        check("halt_high_len", hl, 3);
        check("halt_stays_low", saw_hi, 0);
        check("halt_count", cycle_count, 13);

        // Single step still works with halt held.
        btn_step = 1'b1;
        repeat (14) @(negedge clk);
        check("halt_step_count", cycle_count, 14);
        btn_step = 1'b0;
        run = 1'b0;
        repeat (10) @(negedge clk);
        halt = 1'b0;
        repeat (4) @(negedge clk);

        // Run and step requests in the same idle cycle: run wins.
        btn_step = 1'b1;
        run = 1'b1;
        saw_busy = 0; saw_hi = 0;
        repeat (30) begin
            @(negedge clk);
            if (step_busy) saw_busy = 1;
            if (dbg_clk) saw_hi = 1;
        end
        check("priority_no_step", saw_busy, 0);
        check("priority_run", saw_hi, 1);
        btn_step = 1'b0;

        // Wrap: preload near the top while running.
        @(negedge clk);
        #2;
        count_offset = 16'hFFF8 - m_count;
        force dut.cycle_count = 16'hFFF8;
        #1 release dut.cycle_count;
        rises = 0; cyc = 0; prev = dbg_clk;
        while (rises < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (dbg_clk && !prev) begin
                rises++;
                if (rises == 7) check("wrap_ffff", cycle_count, 16'hFFFF);
                if (rises == 8) check("wrap_zero", cycle_count, 16'h0000);
            end
            prev = dbg_clk;
        end
        check("wrap_rises", rises, 8);

        // Asynchronous reset while dbg_clk is high.
        wait_dbg(1'b1, 10, "rst_wait_high");
        #2;
        rst = 1'b1;
        count_offset = '0;
        #1;
        check("async_rst_dbg_clk", dbg_clk, 0);
        check("async_rst_busy", step_busy, 0);
        check("async_rst_count", cycle_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle_clk", dbg_clk, 0);
            check("post_rst_idle_busy", step_busy, 0);
        end

        // Randomized activity; the per-cycle compare does the checking.
        for (int s = 0; s < 250; s++) begin
            btn_step = 1'($urandom_range(0, 1));
            run      = ($urandom_range(0, 3) == 0);
            halt     = ($urandom_range(0, 2) == 0);
            repeat ($urandom_range(1, 25)) @(negedge clk);
        end
        btn_step = 1'b0;
        run = 1'b0;
        halt = 1'b0;
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
